control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired Moore control unit for the 32-bit bus CPU. Sits directly upstream of the register
//  select/encode stage: generates Gra/Grb/Grc/Rin/Rout/BAout plus every bus-drive, register-load,
//  ALU and memory strobe. Steps fetch (T0-T2) and per-opcode execute (T3-T7) with memory-ready stalls.
// PARAMETERS
//  OPW    5   opcode width (IR[31:27])
//  ALUW   5   alu_op width; encodings in cpu_pkg
// PORTS
//  clock       in   1   rising-edge clock
//  reset_n     in   1   asynchronous active-low reset
//  ir          in   32  instruction register contents (opcode = ir[31:27])
//  con_ff      in   1   branch condition flip-flop
//  mem_ready   in   1   memory completes current Read/Write this cycle
//  stop        in   1   level; halt at next instruction boundary
//  step        in   1   single-step pulse (used only with SINGLE_STEP_EN)
//  gra,grb,grc,rin,rout,ba_out  out 1 each  register select/encode controls
//  pc_out,zlo_out,zhi_out,mdr_out,hi_out,lo_out,inport_out,c_out  out 1 each  bus drivers
//  pc_in,inc_pc,mar_in,mdr_in,ir_in,y_in,z_in,hi_in,lo_in,con_in,outport_in  out 1 each  loads
//  read,write  out  1   memory strobes
//  alu_op      out  ALUW  ALU function, valid with z_in
//  run         out  1   1 while executing; 0 in S_RST/S_HALT/S_STEP
// BEHAVIOUR
//  States (cpu_pkg enum): S_RST,T0..T7,S_HALT,S_STEP. Outputs decoded from state+opcode; all 0 unless listed.
//  reset_n low: state=S_RST immediately; all outputs 0, run=0. S_RST -> T0 next edge.
//  Fetch: T0 pc_out,mar_in,inc_pc,z_in; T1 zlo_out,pc_in,read,mdr_in; T2 mdr_out,ir_in.
//  Stall: in any state asserting read or write, hold state (strobes held) until mem_ready=1;
//   advance on that edge. mem_ready=1 on entry: no stall. pc_in repeat during stall is idempotent.
//  Execute, then -> T0 unless noted:
//   add/sub/and/or/shl/shr/rol/ror/neg/not: T3 grb,rout,y_in; T4 grc,rout,alu_op,z_in; T5 zlo_out,gra,rin.
//   addi/andi/ori: T4 c_out instead of grc,rout.
//   ldi: T3 grb,ba_out,y_in; T4 c_out,alu_op=ADD,z_in; T5 zlo_out,gra,rin.
//   ld: T3-T4 as ldi; T5 zlo_out,mar_in; T6 read,mdr_in (stall); T7 mdr_out,gra,rin.
//   st: T3-T5 as ld; T6 gra,rout,mdr_in; T7 write (stall).
//   mul/div: T3 gra,rout,y_in; T4 grb,rout,alu_op,z_in; T5 zlo_out,lo_in; T6 zhi_out,hi_in.
//   br: T3 gra,rout,con_in; T4 pc_out,y_in; T5 c_out,alu_op=ADD,z_in; T6 zlo_out,pc_in iff con_ff.
//   jr: T3 gra,rout,pc_in. mfhi/mflo: T3 hi_out|lo_out,gra,rin. in: T3 inport_out,gra,rin.
//   out: T3 gra,rout,outport_in. nop and undefined opcodes: T3 no controls.
//   halt: T3 -> S_HALT; S_HALT is sticky until reset_n.
//  Boundary: stop sampled on last execute cycle; if 1 -> S_HALT not T0. Reset mid-stall aborts the access.
//  Exactly one of gra/grb/grc asserted with rin/rout; never rin and rout together.
// CONFIGURATION
//  SINGLE_STEP_EN defined: last execute cycle -> S_STEP (run=0); leaves to T0 on step rising edge
//   (step registered, edge-detected; held-high step advances once). stop takes priority -> S_HALT.
//  Undefined: S_STEP unreachable, step ignored, flow goes straight to T0.
// STRUCTURE
//  cpu_pkg: state_t enum, opcode localparams (ld=00000,ldi=00001,st=00010,add=00011,br=10010,
//   halt=11011, ...), alu_op encodings (ALU_ADD etc.). Shared with ALU and datapath.
//  One sub-module: step_sync (2-flop sync + rising-edge detect), instantiated under SINGLE_STEP_EN.
// TESTING
//  reset_n low mid-T6 of ld -> all outputs 0, run=0; release -> S_RST, T0 on second edge.
//  add (ir=0x1910_0000), mem_ready=1 -> T0..T5 in 6 cycles; T4 alu_op=ALU_ADD, z_in=1; T5 gra,rin.
//  ld with mem_ready low 3 cycles at T6 -> read,mdr_in held 4 cycles; T7 once after.
//  br, con_ff=0 -> T6 pc_in=0; con_ff=1 -> T6 zlo_out,pc_in=1.
//  halt opcode -> S_HALT, run=0, no strobes for 20 cycles despite mem_ready toggling.
//  SINGLE_STEP_EN: step held high 10 cycles -> exactly one instruction executed.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, opcode map and ALU function codes.
// Also used by the ALU and datapath, so encodings here are the single source of truth.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_RST,
        T0, T1, T2, T3, T4, T5, T6, T7,
        S_HALT,
        S_STEP
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10100;
    localparam logic [4:0] OP_OUT  = 5'b10101;
    localparam logic [4:0] OP_MFHI = 5'b10110;
    localparam logic [4:0] OP_MFLO = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Zero is reserved so an idle alu_op is never mistaken for a real function.
    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SHR  = 5'd5;
    localparam logic [4:0] ALU_SHL  = 5'd6;
    localparam logic [4:0] ALU_ROR  = 5'd7;
    localparam logic [4:0] ALU_ROL  = 5'd8;
    localparam logic [4:0] ALU_NEG  = 5'd9;
    localparam logic [4:0] ALU_NOT  = 5'd10;
    localparam logic [4:0] ALU_MUL  = 5'd11;
    localparam logic [4:0] ALU_DIV  = 5'd12;

    function automatic state_t last_exec_state(input logic [4:0] op);
        state_t s;
        s = T3;
        case (op)
            OP_LD, OP_ST:                  s = T7;
            OP_MUL, OP_DIV, OP_BR:         s = T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_NEG, OP_NOT, OP_ADDI, OP_ANDI, OP_ORI:
                                           s = T5;
            default:                       s = T3;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] alu_for_op(input logic [4:0] op);
        logic [4:0] a;
        a = ALU_NONE;
        case (op)
            OP_ADD, OP_ADDI: a = ALU_ADD;
            OP_SUB:          a = ALU_SUB;
            OP_AND, OP_ANDI: a = ALU_AND;
            OP_OR, OP_ORI:   a = ALU_OR;
            OP_SHR:          a = ALU_SHR;
            OP_SHL:          a = ALU_SHL;
            OP_ROR:          a = ALU_ROR;
            OP_ROL:          a = ALU_ROL;
            OP_NEG:          a = ALU_NEG;
            OP_NOT:          a = ALU_NOT;
            OP_MUL:          a = ALU_MUL;
            OP_DIV:          a = ALU_DIV;
            default:         a = ALU_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/step_sync.sv
// Synchronises the asynchronous single-step button and emits a one-cycle pulse per rising edge.
module step_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_step,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_step;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, per-opcode execute T3-T7, memory-ready stalls.
// Optional SINGLE_STEP_EN parks in S_STEP after each instruction until a step button edge.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPW  = 5,
    parameter int unsigned ALUW = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     ir,
    input  logic            con_ff,
    input  logic            mem_ready,
    input  logic            stop,
    input  logic            step,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            ba_out,
    output logic            pc_out,
    output logic            zlo_out,
    output logic            zhi_out,
    output logic            mdr_out,
    output logic            hi_out,
    output logic            lo_out,
    output logic            inport_out,
    output logic            c_out,
    output logic            pc_in,
    output logic            inc_pc,
    output logic            mar_in,
    output logic            mdr_in,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            hi_in,
    output logic            lo_in,
    output logic            con_in,
    output logic            outport_in,
    output logic            read,
    output logic            write,
    output logic [ALUW-1:0] alu_op,
    output logic            run
);

    state_t          r_state;
    state_t          w_next;
    state_t          w_last;
    state_t          w_bound;
    logic [OPW-1:0]  w_op;
    logic            w_stall;
    logic            w_is_rr;
    logic            w_is_imm;
    logic            w_is_mem;
    logic            w_is_muldiv;
    logic            w_unused_ir;

    assign w_op        = ir[31 -: OPW];
    assign w_unused_ir = ^ir[31-OPW:0];

    assign w_is_rr     = w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR,
                                      OP_ROL, OP_NEG, OP_NOT};
    assign w_is_imm    = w_op inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign w_is_mem    = w_op inside {OP_LD, OP_LDI, OP_ST};
    assign w_is_muldiv = w_op inside {OP_MUL, OP_DIV};

`ifdef SINGLE_STEP_EN
    logic w_step_rise;

    step_sync u_step_sync (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_step  (step),
        .o_rise  (w_step_rise)
    );
`else
    logic w_unused_step;
    assign w_unused_step = step;
`endif

    // Any cycle strobing memory holds until the access completes.
    assign w_stall = (read | write) & ~mem_ready;

    always_comb begin
        w_last = last_exec_state(w_op);
`ifdef SINGLE_STEP_EN
        w_bound = stop ? S_HALT : S_STEP;
`else
        w_bound = stop ? S_HALT : T0;
`endif
        w_next = r_state;
        unique case (r_state)
            S_RST:  w_next = T0;
            T0:     w_next = T1;
            T1:     w_next = T2;
            T2:     w_next = T3;
            T3:     w_next = (w_op == OP_HALT) ? S_HALT : ((w_last == T3) ? w_bound : T4);
            T4:     w_next = (w_last == T4) ? w_bound : T5;
            T5:     w_next = (w_last == T5) ? w_bound : T6;
            T6:     w_next = (w_last == T6) ? w_bound : T7;
            T7:     w_next = w_bound;
            S_HALT: w_next = S_HALT;
`ifdef SINGLE_STEP_EN
            S_STEP: w_next = w_step_rise ? T0 : S_STEP;
`else
            S_STEP: w_next = T0;
`endif
            default: w_next = S_RST;
        endcase
        if (w_stall) w_next = r_state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_RST;
        else          r_state <= w_next;
    end

    always_comb begin
        gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; ba_out = 1'b0;
        pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; mdr_out = 1'b0; hi_out = 1'b0;
        lo_out = 1'b0; inport_out = 1'b0; c_out = 1'b0;
        pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; ir_in = 1'b0; y_in = 1'b0;
        z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0; con_in = 1'b0; outport_in = 1'b0;
        read = 1'b0; write = 1'b0;
        alu_op = ALU_NONE;
        run = !(r_state inside {S_RST, S_HALT, S_STEP});
        unique case (r_state)
            T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
            T1: begin zlo_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
            T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            T3: begin
                if (w_is_rr || w_is_imm) begin
                    grb = 1'b1; rout = 1'b1; y_in = 1'b1;
                end else if (w_is_mem) begin
                    grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                end else if (w_is_muldiv) begin
                    gra = 1'b1; rout = 1'b1; y_in = 1'b1;
                end else if (w_op == OP_BR) begin
                    gra = 1'b1; rout = 1'b1; con_in = 1'b1;
                end else if (w_op == OP_JR) begin
                    gra = 1'b1; rout = 1'b1; pc_in = 1'b1;
                end else if (w_op == OP_MFHI) begin
                    hi_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (w_op == OP_MFLO) begin
                    lo_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (w_op == OP_IN) begin
                    inport_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (w_op == OP_OUT) begin
                    gra = 1'b1; rout = 1'b1; outport_in = 1'b1;
                end
            end
            T4: begin
                if (w_is_rr) begin
                    grc = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = alu_for_op(w_op);
                end else if (w_is_imm) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = alu_for_op(w_op);
                end else if (w_is_mem) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD;
                end else if (w_is_muldiv) begin
                    grb = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = alu_for_op(w_op);
                end else if (w_op == OP_BR) begin
                    pc_out = 1'b1; y_in = 1'b1;
                end
            end
            T5: begin
                if (w_is_rr || w_is_imm || w_op == OP_LDI) begin
                    zlo_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (w_op == OP_LD || w_op == OP_ST) begin
                    zlo_out = 1'b1; mar_in = 1'b1;
                end else if (w_is_muldiv) begin
                    zlo_out = 1'b1; lo_in = 1'b1;
                end else if (w_op == OP_BR) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD;
                end
            end
            T6: begin
                if (w_op == OP_LD) begin
                    read = 1'b1; mdr_in = 1'b1;
                end else if (w_op == OP_ST) begin
                    gra = 1'b1; rout = 1'b1; mdr_in = 1'b1;
                end else if (w_is_muldiv) begin
                    zhi_out = 1'b1; hi_in = 1'b1;
                end else if (w_op == OP_BR && con_ff) begin
                    zlo_out = 1'b1; pc_in = 1'b1;
                end
            end
            T7: begin
                if (w_op == OP_LD) begin
                    mdr_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (w_op == OP_ST) begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues expected control vectors per cycle,
// a negedge monitor pops and compares them against the observed outputs.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        con_ff, mem_ready, stop, step;
    logic gra, grb, grc, rin, rout, ba_out, pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out;
    logic inport_out, c_out, pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic con_in, outport_in, read, write, run;
    logic [4:0] alu_op;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .stop(stop), .step(step),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
        .hi_out(hi_out), .lo_out(lo_out), .inport_out(inport_out), .c_out(c_out),
        .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in), .con_in(con_in),
        .outport_in(outport_in), .read(read), .write(write), .alu_op(alu_op), .run(run)
    );

    wire [32:0] w_obs = {alu_op, run, write, read, outport_in, con_in, lo_in, hi_in, z_in, y_in,
                         ir_in, mdr_in, mar_in, inc_pc, pc_in, c_out, inport_out, lo_out, hi_out,
                         mdr_out, zhi_out, zlo_out, pc_out, ba_out, rout, rin, grc, grb, gra};

    localparam logic [32:0] M_GRA = 33'd1 << 0,  M_GRB = 33'd1 << 1,  M_GRC = 33'd1 << 2;
    localparam logic [32:0] M_RIN = 33'd1 << 3,  M_ROUT = 33'd1 << 4, M_BAOUT = 33'd1 << 5;
    localparam logic [32:0] M_PCOUT = 33'd1 << 6, M_ZLO = 33'd1 << 7, M_ZHI = 33'd1 << 8;
    localparam logic [32:0] M_MDROUT = 33'd1 << 9, M_HIOUT = 33'd1 << 10, M_LOOUT = 33'd1 << 11;
    localparam logic [32:0] M_INPORT = 33'd1 << 12, M_COUT = 33'd1 << 13, M_PCIN = 33'd1 << 14;
    localparam logic [32:0] M_INCPC = 33'd1 << 15, M_MARIN = 33'd1 << 16, M_MDRIN = 33'd1 << 17;
    localparam logic [32:0] M_IRIN = 33'd1 << 18, M_YIN = 33'd1 << 19, M_ZIN = 33'd1 << 20;
    localparam logic [32:0] M_HIIN = 33'd1 << 21, M_LOIN = 33'd1 << 22, M_CONIN = 33'd1 << 23;
    localparam logic [32:0] M_OUTPORT = 33'd1 << 24, M_READ = 33'd1 << 25, M_WRITE = 33'd1 << 26;
    localparam logic [32:0] M_RUN = 33'd1 << 27;
    localparam logic [32:0] A_ADD = {5'd1, 28'd0};
    localparam logic [32:0] A_MUL = {5'd11, 28'd0};
    localparam logic [32:0] NONE  = 33'd0;

    localparam logic [32:0] E_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [32:0] E_F1 = M_RUN | M_ZLO | M_PCIN | M_READ | M_MDRIN;
    localparam logic [32:0] E_F2 = M_RUN | M_MDROUT | M_IRIN;
    localparam logic [32:0] E_ADDR3 = M_RUN | M_GRB | M_BAOUT | M_YIN;
    localparam logic [32:0] E_ADDR4 = M_RUN | M_COUT | M_ZIN | A_ADD;
    localparam logic [32:0] E_ADDR5 = M_RUN | M_ZLO | M_MARIN;

    logic [32:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [32:0] mon_exp;
    string       mon_name;

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (w_obs !== mon_exp) begin
                failures++;
                $display("FAIL %s at %0t: got=%h exp=%h", mon_name, $time, w_obs, mon_exp);
            end
        end
    end

    task automatic cyc(input string nm, input logic [32:0] e, input logic mr);
        mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch();
        cyc("T0", E_F0, 1'b1);
        cyc("T1", E_F1, 1'b1);
        cyc("T2", E_F2, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc("rst_low", NONE, 1'b0);
        cyc("rst_low", NONE, 1'b1);
        reset_n = 1'b1;
        cyc("s_rst", NONE, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ir = 32'h0; con_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0; step = 1'b0;
        @(posedge clock);
        #1;
        do_reset();
`ifdef SINGLE_STEP_EN
        ir = {5'b11000, 27'h0};
        fetch();
        cyc("nop_T3", M_RUN, 1'b1);
        for (int i = 0; i < 3; i++) cyc("step_wait", NONE, 1'b1);
        step = 1'b1;
        for (int i = 0; i < 3; i++) cyc("step_sync", NONE, 1'b1);
        fetch();
        cyc("step_T3", M_RUN, 1'b1);
        for (int i = 0; i < 3; i++) cyc("step_held", NONE, 1'b1);
        step = 1'b0;
        for (int i = 0; i < 3; i++) cyc("step_idle", NONE, 1'b1);
`else
        // add
        ir = 32'h1910_0000;
        fetch();
        cyc("add_T3", M_RUN | M_GRB | M_ROUT | M_YIN, 1'b1);
        cyc("add_T4", M_RUN | M_GRC | M_ROUT | M_ZIN | A_ADD, 1'b1);
        cyc("add_T5", M_RUN | M_ZLO | M_GRA | M_RIN, 1'b1);
        // ld with three-cycle memory stall at T6
        ir = {5'b00000, 27'h0400010};
        fetch();
        cyc("ld_T3", E_ADDR3, 1'b1);
        cyc("ld_T4", E_ADDR4, 1'b1);
        cyc("ld_T5", E_ADDR5, 1'b1);
        for (int i = 0; i < 3; i++) cyc("ld_T6_stall", M_RUN | M_READ | M_MDRIN, 1'b0);
        cyc("ld_T6_done", M_RUN | M_READ | M_MDRIN, 1'b1);
        cyc("ld_T7", M_RUN | M_MDROUT | M_GRA | M_RIN, 1'b1);
        // st with one-cycle write stall
        ir = {5'b00010, 27'h0};
        fetch();
        cyc("st_T3", E_ADDR3, 1'b1);
        cyc("st_T4", E_ADDR4, 1'b1);
        cyc("st_T5", E_ADDR5, 1'b1);
        cyc("st_T6", M_RUN | M_GRA | M_ROUT | M_MDRIN, 1'b1);
        cyc("st_T7_stall", M_RUN | M_WRITE, 1'b0);
        cyc("st_T7_done", M_RUN | M_WRITE, 1'b1);
        // mul
        ir = {5'b01110, 27'h0};
        fetch();
        cyc("mul_T3", M_RUN | M_GRA | M_ROUT | M_YIN, 1'b1);
        cyc("mul_T4", M_RUN | M_GRB | M_ROUT | M_ZIN | A_MUL, 1'b1);
        cyc("mul_T5", M_RUN | M_ZLO | M_LOIN, 1'b1);
        cyc("mul_T6", M_RUN | M_ZHI | M_HIIN, 1'b1);
        // addi
        ir = {5'b01011, 27'h0};
        fetch();
        cyc("addi_T3", M_RUN | M_GRB | M_ROUT | M_YIN, 1'b1);
        cyc("addi_T4", M_RUN | M_COUT | M_ZIN | A_ADD, 1'b1);
        cyc("addi_T5", M_RUN | M_ZLO | M_GRA | M_RIN, 1'b1);
        // br not taken, then taken
        for (int t = 0; t < 2; t++) begin
            ir = {5'b10010, 27'h0};
            con_ff = (t == 1);
            fetch();
            cyc("br_T3", M_RUN | M_GRA | M_ROUT | M_CONIN, 1'b1);
            cyc("br_T4", M_RUN | M_PCOUT | M_YIN, 1'b1);
            cyc("br_T5", M_RUN | M_COUT | M_ZIN | A_ADD, 1'b1);
            cyc(t == 1 ? "br_T6_taken" : "br_T6_not_taken",
                t == 1 ? (M_RUN | M_ZLO | M_PCIN) : M_RUN, 1'b1);
        end
        con_ff = 1'b0;
        // single-cycle execute opcodes
        ir = {5'b10011, 27'h0};
        fetch();
        cyc("jr_T3", M_RUN | M_GRA | M_ROUT | M_PCIN, 1'b1);
        ir = {5'b10110, 27'h0};
        fetch();
        cyc("mfhi_T3", M_RUN | M_HIOUT | M_GRA | M_RIN, 1'b1);
        ir = {5'b10101, 27'h0};
        fetch();
        cyc("out_T3", M_RUN | M_GRA | M_ROUT | M_OUTPORT, 1'b1);
        ir = {5'b11110, 27'h0};
        fetch();
        cyc("undef_T3", M_RUN, 1'b1);
        // reset asserted in the middle of a stalled ld
        ir = {5'b00000, 27'h0};
        fetch();
        cyc("ld2_T3", E_ADDR3, 1'b1);
        cyc("ld2_T4", E_ADDR4, 1'b1);
        cyc("ld2_T5", E_ADDR5, 1'b1);
        cyc("ld2_T6_stall", M_RUN | M_READ | M_MDRIN, 1'b0);
        cyc("ld2_T6_stall", M_RUN | M_READ | M_MDRIN, 1'b0);
        do_reset();
        // stop at the boundary of a nop
        ir = {5'b11000, 27'h0};
        fetch();
        stop = 1'b1;
        cyc("nop_T3_stop", M_RUN, 1'b1);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) cyc("stop_halted", NONE, 1'b1);
        // halt opcode is sticky regardless of memory activity
        do_reset();
        ir = {5'b11011, 27'h0};
        fetch();
        cyc("halt_T3", M_RUN, 1'b1);
        for (int i = 0; i < 20; i++) cyc("halt_sticky", NONE, i[0]);
`endif
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
